// File: rtl/mem_arbiter_if.sv
// One memory request channel: request, write-data and read-response handshakes.
// master issues requests and receives responses; slave accepts requests and returns responses.
interface mem_arbiter_if #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128
);
    logic                   req_valid;
    logic                   req_ready;
    logic [ADDR_BITS-1:0]   req_addr;
    logic                   req_rw;
    logic                   req_data_valid;
    logic                   req_data_ready;
    logic [DATA_BITS-1:0]   req_data_bits;
    logic [DATA_BITS/8-1:0] req_data_mask;
    logic                   resp_valid;
    logic [DATA_BITS-1:0]   resp_data;

    modport master (
        output req_valid, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
        input  req_ready, req_data_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
        output req_ready, req_data_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of the I-cache (c0) and D-cache (c1) onto one memory port;
// read responses are routed back in order through an ID FIFO.
module mem_arbiter #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128,
    parameter int MAX_OUTST = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    mem_arbiter_if.slave               c0,
    mem_arbiter_if.slave               c1,
    mem_arbiter_if.master              mem,
    output logic                       err_resp,
    output logic                       dbg_state,
    output logic                       dbg_prio,
    output logic                       dbg_wr_owner,
    output logic [$clog2(MAX_OUTST):0] dbg_count
);
    localparam int PW = $clog2(MAX_OUTST);

    // Handshake rule on every channel: a transfer happens in a cycle where
    // valid and ready are both high; valid never waits on ready.
    typedef enum logic {IDLE = 1'b0, WDATA = 1'b1} state_t;

    state_t                 state, state_next;
    logic                   prio, wr_owner;
    logic [PW:0]            wr_ptr, rd_ptr;
    logic [MAX_OUTST-1:0]   id_mem;
    logic                   full, empty, head, pop;

    logic [1:0]             req_valid, req_rw, data_valid, elig, req_ready, data_ready;
    logic [ADDR_BITS-1:0]   addr [2];
    logic [DATA_BITS-1:0]   bits [2];
    logic [DATA_BITS/8-1:0] mask [2];
    logic                   winner, owner, grant_ok, data_active, req_hs, data_hs;

    assign req_valid  = {c1.req_valid, c0.req_valid};
    assign req_rw     = {c1.req_rw, c0.req_rw};
    assign data_valid = {c1.req_data_valid, c0.req_data_valid};
    assign addr[0] = c0.req_addr;
    assign addr[1] = c1.req_addr;
    assign bits[0] = c0.req_data_bits;
    assign bits[1] = c1.req_data_bits;
    assign mask[0] = c0.req_data_mask;
    assign mask[1] = c1.req_data_mask;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = id_mem[rd_ptr[PW-1:0]];
    assign pop   = mem.resp_valid && !empty;

    always_comb begin
        elig[0] = req_valid[0] && (req_rw[0] || !full);
        elig[1] = req_valid[1] && (req_rw[1] || !full);
        winner  = elig[prio] ? prio : !prio;
        grant_ok = (state == IDLE) && (elig != 2'b00);
        req_hs   = grant_ok && mem.req_ready;
        owner    = (state == IDLE) ? winner : wr_owner;
        // In IDLE the data beat only travels with an accepted write request, so a
        // stalled request can never have its data consumed ahead of it.
        data_active = (state == WDATA) || (req_hs && req_rw[winner]);
        data_hs     = data_active && data_valid[owner] && mem.req_data_ready;

        mem.req_valid      = grant_ok;
        mem.req_addr       = addr[winner];
        mem.req_rw         = req_rw[winner];
        mem.req_data_valid = data_active && data_valid[owner];
        mem.req_data_bits  = bits[owner];
        mem.req_data_mask  = mask[owner];

        req_ready  = 2'b00;
        data_ready = 2'b00;
        if (grant_ok) req_ready[winner] = mem.req_ready;
        if (data_active) data_ready[owner] = mem.req_data_ready;

        state_next = state;
        case (state)
            IDLE:    if (req_hs && req_rw[winner] && !data_hs) state_next = WDATA;
            WDATA:   if (data_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign c0.req_ready      = req_ready[0];
    assign c1.req_ready      = req_ready[1];
    assign c0.req_data_ready = data_ready[0];
    assign c1.req_data_ready = data_ready[1];
    assign c0.resp_valid     = pop && !head;
    assign c1.resp_valid     = pop && head;
    assign c0.resp_data      = mem.resp_data;
    assign c1.resp_data      = mem.resp_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            prio     <= 1'b0;
            wr_owner <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            id_mem   <= '0;
            err_resp <= 1'b0;
        end else begin
            state <= state_next;
            if (req_hs) prio <= !winner;
            if (state == IDLE && state_next == WDATA) wr_owner <= winner;
            if (req_hs && !req_rw[winner]) begin
                id_mem[wr_ptr[PW-1:0]] <= winner;
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (PW+1)'(1);
            if (mem.resp_valid && empty) err_resp <= 1'b1;
        end
    end

    assign dbg_state    = (state == WDATA);
    assign dbg_prio     = prio;
    assign dbg_wr_owner = wr_owner;
    assign dbg_count    = wr_ptr - rd_ptr;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-client arbiter between the instruction cache (client 0) and the data cache (client 1) and the single external memory port. It sits directly downstream of both cache instances and upstream of the memory model/DRAM controller. Requests pass through combinationally under round-robin arbitration. Write data stays bound to the client that won the write. Read responses return in order and are routed back by a small ID FIFO.

## Interface
- ADDR_BITS, 28, memory line address width (CPU word address minus 2 bits)
- DATA_BITS, 128, memory data width (`MEM_DATA_BITS)
- MAX_OUTST, 4, max outstanding reads (ID FIFO depth, power of 2)

Ports, all `cN_*` present for N = 0, 1:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cN_req_valid / cN_req_ready  in/out  1  request handshake
- cN_req_addr  in  ADDR_BITS  line address
- cN_req_rw  in  1  1 = write, 0 = read
- cN_req_data_valid / cN_req_data_ready  in/out  1  write-data handshake
- cN_req_data_bits  in  DATA_BITS  write data
- cN_req_data_mask  in  DATA_BITS/8  byte mask
- cN_resp_valid  out  1  read response to client N
- cN_resp_data  out  DATA_BITS  response data (shared copy of mem_resp_data)
- mem_req_valid / mem_req_ready  out/in  1  request handshake
- mem_req_addr  out  ADDR_BITS
- mem_req_rw  out  1
- mem_req_data_valid / mem_req_data_ready  out/in  1
- mem_req_data_bits  out  DATA_BITS
- mem_req_data_mask  out  DATA_BITS/8
- mem_resp_valid  in  1
- mem_resp_data  in  DATA_BITS
- err_resp  out  1  sticky flag: response arrived with the ID FIFO empty

## Operation
- The state machine has two states.
  - IDLE: accepts requests.
  - WDATA: waits for the write-data beat from wr_owner.
- Priority pointer `prio` (1 bit), reset 0.
  - Winner is client `prio` if its req_valid is high, otherwise the other client if its req_valid is high.
  - A read is eligible only when the FIFO is not full. A write is always eligible.
  - After every request handshake, `prio` becomes the other client (not the winner).
- Request handshake occurs only in IDLE.
  - mem_req_valid = an eligible winner exists.
  - mem_req_addr and mem_req_rw are muxed from the winner.
  - Winner's cN_req_ready = mem_req_ready. Loser's ready = 0.
  - In WDATA, all cN_req_ready = 0 and mem_req_valid = 0.
- Reads: on handshake, push the winner ID into the FIFO.
- Writes: no FIFO push.
  - Data owner is the winner while in IDLE, and wr_owner while in WDATA.
  - mem_req_data_valid/bits/mask are muxed from the owner.
  - Owner's data_ready = mem_req_data_ready. Non-owner data_ready = 0, and its data_valid is ignored.
  - If the data beat completes in the same cycle as the request, stay in IDLE.
  - Otherwise latch wr_owner and go to WDATA. Return to IDLE on the data handshake.
- Responses: memory returns exactly one beat per read, in issue order.
  - On mem_resp_valid, cN_resp_valid = 1 for N = FIFO head. Pop in the same cycle.
  - Empty FIFO: drop the beat and set err_resp.
- FIFO push and pop in the same cycle are allowed. When full, a read is ineligible even if a pop occurs that cycle.
- Client rule: cN_req_valid and cN_req_data_valid must not depend combinationally on the corresponding ready.

## Timing
- Reset values:
  - All cN_req_ready, cN_req_data_ready, cN_resp_valid, mem_req_valid, mem_req_data_valid = 0.
  - err_resp = 0, state = IDLE, FIFO empty, prio = 0, wr_owner = 0.
  - cN_resp_data and mem_req_* payload are don't-care while their valids are low.
- Latency:
  - Request path is 0 cycles (combinational pass-through).
  - Response routing is 0 cycles (mem_resp_valid to cN_resp_valid in the same cycle).
- Simultaneous valid requests from both clients alternate each handshake. No client waits more than one grant.
- A stalled winner (mem_req_ready = 0) does not move `prio`. Arbitration is re-evaluated every cycle.
- Reset mid-write or with reads outstanding: the FIFO is cleared. Memory is reset in the same cycle, so no stale responses are expected.
- Pointer wrap-around: FIFO pointers are log2(MAX_OUTST)+1 bits to distinguish full from empty.

## Test plan
- Both clients issue reads to 0x10 and 0x20 in the same cycle, mem_req_ready = 1 → c0 granted in cycle 0, c1 in cycle 1. Responses 0xA, 0xB return in order → c0 gets 0xA, c1 gets 0xB.
- c1 issues a write to 0x30 with data_valid held low for 3 cycles → WDATA entered, all cN_req_ready = 0. c0 read is stalled until the beat completes, then granted the next cycle.
- Write where request and data handshake in the same cycle → no WDATA visit. The next request is granted in the following cycle.
- c0 issues 4 reads with no responses → 5th read blocked (c0_req_ready = 0). c1 write still granted. After one response, the 5th read is granted.
- mem_resp_valid pulsed with no outstanding reads → no cN_resp_valid, err_resp = 1 and held until reset.
- Assert reset while in WDATA with 2 reads outstanding → next cycle all outputs 0, FIFO empty, prio = 0, state IDLE.
